// File: rtl/layer_sequencer.sv
// layer_sequencer: streams x/w/b from synchronous-read memories through one neuron, once per neuron of a dense layer.
// Define LAYER_SEQ_WATCHDOG_EN to abort the layer when the neuron stalls in WAIT for TIMEOUT cycles.
module layer_sequencer #(
    parameter int N = 4,
    parameter int M = 4,
    parameter int TIMEOUT = 255,
    localparam int XAW = (N > 1) ? $clog2(N) : 1,
    localparam int WAW = (N * M > 1) ? $clog2(N * M) : 1,
    localparam int BAW = (M > 1) ? $clog2(M) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  layer_done,
    output logic                  err,
    output logic [XAW-1:0]        x_addr,
    input  logic signed [15:0]    x_data,
    output logic [WAW-1:0]        w_addr,
    input  logic signed [15:0]    w_data,
    output logic [BAW-1:0]        b_addr,
    input  logic signed [15:0]    b_data,
    output logic                  n_start,
    output logic signed [15:0]    n_x,
    output logic signed [15:0]    n_w,
    output logic signed [15:0]    n_b,
    input  logic signed [15:0]    n_activation,
    input  logic                  n_done,
    output logic                  y_valid,
    output logic [BAW-1:0]        y_idx,
    output logic signed [15:0]    y_data
);
    typedef enum logic [2:0] {IDLE, FETCH, STREAM, WAIT, EMIT, DONE} state_t;
    state_t state;
    logic [BAW-1:0] j;
    logic [XAW-1:0] k;
    logic [XAW-1:0] a_nxt;
`ifdef LAYER_SEQ_WATCHDOG_EN
    localparam int WDW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [WDW-1:0] wd;
`else
    assign err = TIMEOUT < 0;
`endif
    // Addresses run one pair ahead of k because the memories answer a cycle late.
    always_comb begin
        a_nxt = (state == FETCH) ? XAW'(N > 1) :
                ((int'(k) + 2 < N) ? XAW'(int'(k) + 2) : XAW'(N - 1));
    end
    assign n_x = (state == STREAM) ? x_data : '0;
    assign n_w = (state == STREAM) ? w_data : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            j          <= '0;
            k          <= '0;
            busy       <= 1'b0;
            layer_done <= 1'b0;
            n_start    <= 1'b0;
            y_valid    <= 1'b0;
            x_addr     <= '0;
            w_addr     <= '0;
            b_addr     <= '0;
            n_b        <= '0;
            y_idx      <= '0;
            y_data     <= '0;
`ifdef LAYER_SEQ_WATCHDOG_EN
            wd         <= '0;
            err        <= 1'b0;
`endif
        end else begin
            n_start    <= 1'b0;
            y_valid    <= 1'b0;
            layer_done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state  <= FETCH;
                    busy   <= 1'b1;
                    j      <= '0;
                    x_addr <= '0;
                    w_addr <= '0;
                    b_addr <= '0;
`ifdef LAYER_SEQ_WATCHDOG_EN
                    err    <= 1'b0;
`endif
                end
                FETCH: begin
                    state   <= STREAM;
                    k       <= '0;
                    n_start <= 1'b1;
                    x_addr  <= a_nxt;
                    w_addr  <= WAW'(int'(j) * N + int'(a_nxt));
                end
                STREAM: begin
                    if (k == '0) n_b <= b_data;
                    if (k == XAW'(N - 1)) begin
                        state <= WAIT;
`ifdef LAYER_SEQ_WATCHDOG_EN
                        wd    <= '0;
`endif
                    end else begin
                        k      <= k + XAW'(1);
                        x_addr <= a_nxt;
                        w_addr <= WAW'(int'(j) * N + int'(a_nxt));
                    end
                end
                WAIT: begin
                    if (n_done) begin
                        state   <= EMIT;
                        y_data  <= n_activation;
                        y_valid <= 1'b1;
                        y_idx   <= j;
                    end
`ifdef LAYER_SEQ_WATCHDOG_EN
                    else if (wd == WDW'(TIMEOUT)) begin
                        state      <= DONE;
                        layer_done <= 1'b1;
                        err        <= 1'b1;
                    end else wd <= wd + WDW'(1);
`endif
                end
                EMIT: if (j == BAW'(M - 1)) begin
                    state      <= DONE;
                    layer_done <= 1'b1;
                end else begin
                    state  <= FETCH;
                    j      <= j + BAW'(1);
                    x_addr <= '0;
                    w_addr <= WAW'((int'(j) + 1) * N);
                    b_addr <= j + BAW'(1);
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
